gate_resp_checker: RTL
======================

Name: gate_resp_checker

Overview:
- Synthesizable response checker for the basic-gate stimulus benches; the receiving end of a gate test.
- Samples the gate inputs (A_i, B_i) together with the DUT output (F_i) on each valid strobe and compares F_i to the expected value for the selected gate function.
- Counts vectors and mismatches, tracks input-combination coverage and reports pass/fail.
- Sits beside any basic gate DUT; the stimulus source drives vld_i.

Parameters:
- CNT_W, 8, width of vector and error counters; both saturate at 2^CNT_W-1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  pulse; begins a check run and clears all results.
- stop_i  input  1  pulse; ends the run.
- op_i  input  3  gate under test, latched at start: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (B ignored), 7 BUF A (B ignored).
- vld_i  input  1  A_i/B_i/F_i are valid this cycle.
- A_i  input  1  gate input A as applied to the DUT.
- B_i  input  1  gate input B as applied to the DUT.
- F_i  input  1  DUT output observed.
- busy_o  output  1  high in RUN.
- done_o  output  1  high in DONE.
- pass_o  output  1  done_o & (err_cnt_o==0) & (cov_o==4'hF) & (vec_cnt_o!=0).
- vec_cnt_o  output  CNT_W  vectors checked.
- err_cnt_o  output  CNT_W  mismatches.
- cov_o  output  4  bit {A,B} set once that input combination has been checked.
- first_err_o  output  3  {A,B,F} of the first mismatch; 0 if none.

Behaviour:
- Reset (async, rst_n_i low): state IDLE. All outputs 0 and latched op 0. Effective immediately at any point, including mid-run. A pending vector is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i.
  - RUN -> DONE on stop_i.
  - DONE -> RUN on start_i; otherwise DONE holds indefinitely.
  - start_i in RUN is ignored. stop_i in IDLE or DONE is ignored.
- Entering RUN (the start_i cycle): latch op_i, and clear vec_cnt_o, err_cnt_o, cov_o and first_err_o at the same edge.
- Checking: only in RUN with vld_i=1. exp = f(op,A_i,B_i); mismatch = (F_i != exp).
- Result update (registered, one cycle after the sampled vld_i):
  - vec_cnt_o increments.
  - err_cnt_o increments on mismatch.
  - cov_o[{A_i,B_i}] is set.
  - On the first mismatch of the run (err_cnt_o was 0), first_err_o <= {A_i,B_i,F_i}.
- Counters saturate; no wrap. At vec_cnt_o = 2^CNT_W-1, further vectors still update err_cnt_o (saturating), cov_o and first_err_o.
- vld_i with stop_i in the same RUN cycle: the vector is checked and counted, and DONE is entered at the same edge.
- vld_i outside RUN is ignored.
- For ops 6/7, B is don't-care for exp, but cov_o still records {A,B}.
- Outputs hold their values in DONE until the next start_i or reset.

Optional Feature:
- Macro GATE_CHK_PIPE_EN.
- Defined:
  - A_i/B_i/F_i/vld_i are registered once before comparison; result latency is 2 cycles after vld_i.
  - On stop_i, the FSM goes through one drain cycle before DONE (busy_o stays high through the drain), so a vector accepted with or just before stop_i is counted before done_o rises.
  - start_i clears the input stage too.
- Undefined: single-cycle latency as above; no drain cycle.

Test Plan:
- op=5 (XNOR); vectors {0,0,1},{1,0,0},{0,1,0},{1,1,1}; stop -> vec_cnt_o=4, err_cnt_o=0, cov_o=4'hF, pass_o=1, done_o=1.
- op=5; vectors {0,0,1},{1,0,1},{0,1,1},{1,1,1}; stop -> err_cnt_o=2, first_err_o=3'b101, pass_o=0.
- op=0 (AND); only {0,0,0},{1,1,1} applied; stop -> err_cnt_o=0, cov_o=4'b1001, pass_o=0.
- CNT_W=2, op=1 (OR); 5 correct vectors -> vec_cnt_o=3 (saturated), cov_o updated, no wrap.
- RUN with 2 vectors, rst_n_i pulsed low mid-cycle -> all outputs 0 asynchronously, state IDLE. New start_i with op=2 runs cleanly from zero.
- vld_i={1,1,0} with stop_i in the same cycle, op=2 -> vec_cnt_o=1, err_cnt_o=0, done_o=1; with GATE_CHK_PIPE_EN, busy_o stays high for the drain cycle, then done_o=1.

Source files
------------

// File: rtl/gate_resp_checker_if.sv
// Observed gate vector bus: strobe, gate inputs A/B and the DUT output F.
// The stimulus source drives it; the response checker samples it.
interface gate_resp_checker_if;
    logic vld;
    logic a;
    logic b;
    logic f;

    modport master (output vld, a, b, f);
    modport slave  (input  vld, a, b, f);
endinterface

// File: rtl/gate_resp_checker.sv
// Response checker for basic-gate benches: counts vectors, mismatches, coverage.
// Define GATE_CHK_PIPE_EN to register the bus before comparison (adds drain cycle).
module gate_resp_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [2:0]       op_i,
    gate_resp_checker_if.slave bus,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] vec_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [3:0]       cov_o,
    output logic [2:0]       first_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] vec_q;
    logic [CNT_W-1:0] err_q;
    logic [3:0]       cov_q;
    logic [2:0]       first_q;

    logic c_vld;
    logic c_a;
    logic c_b;
    logic c_f;
    logic exp_d;
    logic mis_d;

`ifdef GATE_CHK_PIPE_EN
    logic p_vld_q;
    logic p_a_q;
    logic p_b_q;
    logic p_f_q;

    assign c_vld = p_vld_q;
    assign c_a   = p_a_q;
    assign c_b   = p_b_q;
    assign c_f   = p_f_q;
`else
    assign c_vld = bus.vld & (state_q == S_RUN);
    assign c_a   = bus.a;
    assign c_b   = bus.b;
    assign c_f   = bus.f;
`endif

    always_comb begin
        exp_d = 1'b0;
        unique case (op_q)
            3'd0: exp_d = c_a & c_b;
            3'd1: exp_d = c_a | c_b;
            3'd2: exp_d = c_a ^ c_b;
            3'd3: exp_d = ~(c_a & c_b);
            3'd4: exp_d = ~(c_a | c_b);
            3'd5: exp_d = ~(c_a ^ c_b);
            3'd6: exp_d = ~c_a;
            3'd7: exp_d = c_a;
            default: exp_d = 1'b0;
        endcase
    end

    assign mis_d = (c_f != exp_d);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vec_q   <= '0;
            err_q   <= '0;
            cov_q   <= '0;
            first_q <= '0;
`ifdef GATE_CHK_PIPE_EN
            p_vld_q <= 1'b0;
            p_a_q   <= 1'b0;
            p_b_q   <= 1'b0;
            p_f_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        op_q    <= op_i;
                        vec_q   <= '0;
                        err_q   <= '0;
                        cov_q   <= '0;
                        first_q <= '0;
                    end
                end
                S_RUN: begin
                    if (stop_i) begin
`ifdef GATE_CHK_PIPE_EN
                        state_q <= S_DRAIN;
`else
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase

            // Start is only honoured outside RUN/DRAIN, so it never races a check.
            if (c_vld) begin
                if (vec_q != '1) vec_q <= vec_q + 1'b1;
                if (mis_d && (err_q != '1)) err_q <= err_q + 1'b1;
                if (mis_d && (err_q == '0)) first_q <= {c_a, c_b, c_f};
                cov_q[{c_a, c_b}] <= 1'b1;
            end

`ifdef GATE_CHK_PIPE_EN
            if (state_q == S_RUN) begin
                p_vld_q <= bus.vld;
                p_a_q   <= bus.a;
                p_b_q   <= bus.b;
                p_f_q   <= bus.f;
            end else begin
                p_vld_q <= 1'b0;
                p_a_q   <= 1'b0;
                p_b_q   <= 1'b0;
                p_f_q   <= 1'b0;
            end
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign vec_cnt_o   = vec_q;
    assign err_cnt_o   = err_q;
    assign cov_o       = cov_q;
    assign first_err_o = first_q;
    assign pass_o      = done_q & (err_q == '0) & (cov_q == 4'hF)
                       & (vec_q != '0);

endmodule
